floor_request_queue: RTL and testbench
======================================

// Module: floor_request_queue
// PURPOSE
// Request-entry side of the elevator: captures debounced floor calls from KEY/SW into a pending bitmap.
// Clears each call when the car reports it has been served, and selects the next target floor (SCAN order).
// The state controller consumes floor_reg/target_*; its busy_clear pulse drives serve_ack.
// PARAMETERS
// NUM_FLOORS       10         floors; bit i = floor i+1
// DEBOUNCE_CYCLES  1_000_000  consecutive stable CLOCK_50 cycles to accept a press/release (20 ms)
// PORTS
// CLOCK_50     in   1   system clock, 50 MHz
// rst          in   1   reset, asynchronous, active-high
// key_n        in   1   raw request button, active-low, asynchronous (KEY[0])
// floor_sel    in   4   binary floor number 1..NUM_FLOORS (SW[3:0]), sampled at accept
// cur_floor    in   10  one-hot car position
// direction    in   1   car travel direction, 1=UP 0=DOWN
// serve_ack    in   1   1-cycle pulse: car finished serving cur_floor
// floor_reg    out  10  pending request bitmap
// req_valid    out  1   floor_reg != 0
// target_floor out  10  one-hot next floor to serve, 0 if none
// target_above out  1   target strictly above cur_floor
// target_below out  1   target strictly below cur_floor
// pend_count   out  4   popcount(floor_reg)
// reject       out  1   1-cycle pulse: accepted press had floor_sel 0 or >NUM_FLOORS
// BEHAVIOUR
// - Reset: all outputs 0, bitmap 0, debounce FSM in IDLE, counter 0, sync flops 1.
// - key_n passes a 2-flop synchronizer (key_s); no logic on raw key_n.
// - Debounce FSM: IDLE -(key_s=0)-> PRESS_WAIT; PRESS_WAIT counts consecutive key_s=0 cycles,
//   key_s=1 -> IDLE, count hits DEBOUNCE_CYCLES -> HELD with 1-cycle accept pulse;
//   HELD -(key_s=1)-> REL_WAIT; REL_WAIT counts key_s=1, key_s=0 -> HELD, full count -> IDLE.
//   Exactly one accept per press regardless of hold length; bounces shorter than count are ignored.
// - Key held low through reset release is a new press (accepted after DEBOUNCE_CYCLES).
// - On accept: floor_sel in 1..NUM_FLOORS sets floor_reg[floor_sel-1] next edge; else reject pulses, no bit set.
// - Re-requesting an already-pending floor: no change, no reject. Request for cur_floor is set normally.
// - serve_ack clears floor_reg bit matching cur_floor next edge. Same-cycle accept for that floor: clear wins, accept dropped.
// - Accept and serve_ack on different floors in one cycle: both applied.
// - cur_floor not one-hot (0 or >1 bit): serve_ack ignored; target_floor=0, target_above/below=0.
// - Target select (registered, 1 cycle after floor_reg/cur_floor/direction change):
//   UP: lowest pending bit above cur_floor; else highest pending below; else cur_floor bit if pending.
//   DOWN: highest pending below; else lowest pending above; else cur_floor bit if pending.
//   No pending -> target_floor=0.
// - target_above/below derived from target_floor vs cur_floor; both 0 when target==cur_floor or 0.
// - req_valid and pend_count registered in the same cycle as target_floor.
// - Latency: first key_s=0 cycle T -> accept at T+DEBOUNCE_CYCLES -> floor_reg at +1 -> target at +2.
// - rst mid-operation: immediate return to reset values; in-progress debounce discarded.
// TESTING (sim with DEBOUNCE_CYCLES=4)
// 1. floor_sel=5, key_n low 10 cycles -> floor_reg=10'h010, pend_count=1, single accept, reject=0.
// 2. key_n glitches low 2 cycles, 5x -> floor_reg unchanged; then hold 50 cycles -> exactly one set.
// 3. floor_sel=0 and floor_sel=12 presses -> reject pulses once each, floor_reg stays 0.
// 4. cur_floor=floor 4, pending {2,6,9}, direction=UP -> target=floor 6, target_above=1; DOWN -> floor 2.
// 5. cur_floor=floor 6 pending {6}, serve_ack with same-cycle accept of floor 6 -> floor_reg=0, req_valid=0.
// 6. rst asserted in PRESS_WAIT with pending {3} -> all outputs 0; no accept after release unless key still low.

Source files
------------

// File: rtl/floor_request_queue.sv
// Elevator request entry: debounces the call button, keeps a pending-floor bitmap and
// picks the next target floor in SCAN order relative to the car position and direction.
module floor_request_queue #(
    parameter int NUM_FLOORS      = 10,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                  CLOCK_50,
    input  logic                  rst,
    input  logic                  key_n_i,
    input  logic [3:0]            floor_sel_i,
    input  logic [NUM_FLOORS-1:0] cur_floor_i,
    input  logic                  direction_i,
    input  logic                  serve_ack_i,
    output logic [NUM_FLOORS-1:0] floor_reg_o,
    output logic                  req_valid_o,
    output logic [NUM_FLOORS-1:0] target_floor_o,
    output logic                  target_above_o,
    output logic                  target_below_o,
    output logic [3:0]            pend_count_o,
    output logic                  reject_o
);

    localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_MAX  = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
    localparam logic [3:0]      MAX_SEL = 4'(NUM_FLOORS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS_WAIT,
        ST_HELD,
        ST_REL_WAIT
    } db_state_t;

    // ------------------------------------------------------------------
    // Helpers for the target search
    // ------------------------------------------------------------------
    function automatic logic [NUM_FLOORS-1:0] lowest_bit(input logic [NUM_FLOORS-1:0] v);
        logic [NUM_FLOORS-1:0] r;
        logic                  found;
        r     = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (v[i] && !found) begin
                r[i]  = 1'b1;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [NUM_FLOORS-1:0] highest_bit(input logic [NUM_FLOORS-1:0] v);
        logic [NUM_FLOORS-1:0] r;
        logic                  found;
        r     = '0;
        found = 1'b0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (v[i] && !found) begin
                r[i]  = 1'b1;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [3:0] popcount(input logic [NUM_FLOORS-1:0] v);
        logic [3:0] c;
        c = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                  key_meta_q, key_s_q;
    db_state_t             state_q, state_d;
    logic [DB_W-1:0]       cnt_q, cnt_d;
    logic [NUM_FLOORS-1:0] floor_q, floor_d;
    logic [NUM_FLOORS-1:0] target_q, target_d;
    logic                  above_q, above_d;
    logic                  below_q, below_d;
    logic                  req_valid_q, req_valid_d;
    logic [3:0]            count_q, count_d;
    logic                  reject_q, reject_d;

    logic                  accept;

    // ------------------------------------------------------------------
    // Debounce FSM: one accept per press, bounces shorter than the count ignored
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!key_s_q) begin
                    state_d = ST_PRESS_WAIT;
                    cnt_d   = DB_ONE;
                end
            end
            ST_PRESS_WAIT: begin
                if (key_s_q) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DB_MAX) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                    accept  = 1'b1;
                end else begin
                    cnt_d = cnt_q + DB_ONE;
                end
            end
            ST_HELD: begin
                if (key_s_q) begin
                    state_d = ST_REL_WAIT;
                    cnt_d   = DB_ONE;
                end
            end
            ST_REL_WAIT: begin
                if (!key_s_q) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                end else if (cnt_q == DB_MAX) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + DB_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pending bitmap and target selection
    // ------------------------------------------------------------------
    logic                  sel_valid;
    logic                  cur_valid;
    logic [NUM_FLOORS-1:0] set_vec, clr_vec;
    logic [NUM_FLOORS-1:0] below_mask, above_mask;
    logic [NUM_FLOORS-1:0] up_pick, down_pick, here_pick;

    always_comb begin
        below_mask = cur_floor_i - NUM_FLOORS'(1);
        above_mask = ~(below_mask | cur_floor_i);
        cur_valid  = (cur_floor_i != '0) && ((cur_floor_i & below_mask) == '0);

        sel_valid  = (floor_sel_i != 4'd0) && (floor_sel_i <= MAX_SEL);
        set_vec    = '0;
        if (accept && sel_valid) begin
            set_vec = NUM_FLOORS'(1) << (floor_sel_i - 4'd1);
        end
        clr_vec    = (serve_ack_i && cur_valid) ? cur_floor_i : '0;
        reject_d   = accept && !sel_valid;

        // Clear is applied after set so a same-cycle request for the served floor is dropped.
        floor_d    = (floor_q | set_vec) & ~clr_vec;

        up_pick    = lowest_bit(floor_q & above_mask);
        down_pick  = highest_bit(floor_q & below_mask);
        here_pick  = floor_q & cur_floor_i;

        target_d   = '0;
        if (cur_valid) begin
            if (direction_i) begin
                if (up_pick != '0)        target_d = up_pick;
                else if (down_pick != '0) target_d = down_pick;
                else                      target_d = here_pick;
            end else begin
                if (down_pick != '0)      target_d = down_pick;
                else if (up_pick != '0)   target_d = up_pick;
                else                      target_d = here_pick;
            end
        end
        above_d     = |(target_d & above_mask);
        below_d     = |(target_d & below_mask);
        req_valid_d = |floor_q;
        count_d     = popcount(floor_q);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            key_meta_q  <= 1'b1;
            key_s_q     <= 1'b1;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            floor_q     <= '0;
            target_q    <= '0;
            above_q     <= 1'b0;
            below_q     <= 1'b0;
            req_valid_q <= 1'b0;
            count_q     <= '0;
            reject_q    <= 1'b0;
        end else begin
            key_meta_q  <= key_n_i;
            key_s_q     <= key_meta_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            floor_q     <= floor_d;
            target_q    <= target_d;
            above_q     <= above_d;
            below_q     <= below_d;
            req_valid_q <= req_valid_d;
            count_q     <= count_d;
            reject_q    <= reject_d;
        end
    end

    assign floor_reg_o    = floor_q;
    assign req_valid_o    = req_valid_q;
    assign target_floor_o = target_q;
    assign target_above_o = above_q;
    assign target_below_o = below_q;
    assign pend_count_o   = count_q;
    assign reject_o       = reject_q;

endmodule

// File: tb/tb_floor_request_queue.sv
// Directed bench for floor_request_queue with a short debounce count: table-driven SCAN
// target vectors plus hand-written sequences for debounce, reject, clear-wins and reset.
module tb_floor_request_queue;

    logic       CLOCK_50 = 1'b0;
    logic       rst;
    logic       key_n;
    logic [3:0] floor_sel;
    logic [9:0] cur_floor;
    logic       direction;
    logic       serve_ack;
    logic [9:0] floor_reg;
    logic       req_valid;
    logic [9:0] target_floor;
    logic       target_above;
    logic       target_below;
    logic [3:0] pend_count;
    logic       reject;

    int n_tests = 0;
    int n_fail  = 0;
    int rej_cnt = 0;
    logic [9:0] model = '0;

    floor_request_queue #(
        .NUM_FLOORS      (10),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .CLOCK_50       (CLOCK_50),
        .rst            (rst),
        .key_n_i        (key_n),
        .floor_sel_i    (floor_sel),
        .cur_floor_i    (cur_floor),
        .direction_i    (direction),
        .serve_ack_i    (serve_ack),
        .floor_reg_o    (floor_reg),
        .req_valid_o    (req_valid),
        .target_floor_o (target_floor),
        .target_above_o (target_above),
        .target_below_o (target_below),
        .pend_count_o   (pend_count),
        .reject_o       (reject)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Counts cycles with reject high; one press must give exactly one cycle.
    always @(negedge CLOCK_50) begin
        if (reject === 1'b1) rej_cnt = rej_cnt + 1;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string      name;
        logic [9:0] pending;
        logic [9:0] cur;
        logic       dir;
        logic [9:0] exp_target;
        logic       exp_above;
        logic       exp_below;
    } vec_t;

    vec_t vecs[13];

    task automatic step(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic press(input logic [3:0] sel, input int low_cycles);
        floor_sel = sel;
        key_n     = 1'b0;
        step(low_cycles);
        key_n     = 1'b1;
        step(12);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_floor_reg"}, 32'(floor_reg), 32'h0);
        check({tag, "_req_valid"}, 32'(req_valid), 32'h0);
        check({tag, "_target"},    32'(target_floor), 32'h0);
        check({tag, "_above"},     32'(target_above), 32'h0);
        check({tag, "_below"},     32'(target_below), 32'h0);
        check({tag, "_count"},     32'(pend_count), 32'h0);
        check({tag, "_reject"},    32'(reject), 32'h0);
    endtask

    // Brings the pending bitmap to p using serve_ack clears and button presses.
    task automatic load_pending(input logic [9:0] p);
        for (int i = 0; i < 10; i++) begin
            if (model[i] && !p[i]) begin
                cur_floor = 10'd1 << i;
                serve_ack = 1'b1;
                step(1);
                serve_ack = 1'b0;
                model[i]  = 1'b0;
            end
        end
        for (int i = 0; i < 10; i++) begin
            if (!model[i] && p[i]) begin
                press(4'(i + 1), 10);
                model[i] = 1'b1;
            end
        end
        step(2);
        check("load_pending", 32'(floor_reg), 32'(p));
    endtask

    initial begin
        int rej0;

        vecs[0]  = '{"up_f4",         10'h122, 10'h008, 1'b1, 10'h020, 1'b1, 1'b0};
        vecs[1]  = '{"down_f4",       10'h122, 10'h008, 1'b0, 10'h002, 1'b0, 1'b1};
        vecs[2]  = '{"up_f9_reverse", 10'h122, 10'h100, 1'b1, 10'h020, 1'b0, 1'b1};
        vecs[3]  = '{"down_f1_rev",   10'h122, 10'h001, 1'b0, 10'h002, 1'b1, 1'b0};
        vecs[4]  = '{"cur_two_hot",   10'h122, 10'h00C, 1'b1, 10'h000, 1'b0, 1'b0};
        vecs[5]  = '{"cur_zero",      10'h122, 10'h000, 1'b0, 10'h000, 1'b0, 1'b0};
        vecs[6]  = '{"only_cur_up",   10'h010, 10'h010, 1'b1, 10'h010, 1'b0, 1'b0};
        vecs[7]  = '{"only_cur_down", 10'h010, 10'h010, 1'b0, 10'h010, 1'b0, 1'b0};
        vecs[8]  = '{"f10_up_below",  10'h010, 10'h200, 1'b1, 10'h010, 1'b0, 1'b1};
        vecs[9]  = '{"down_f10",      10'h201, 10'h200, 1'b0, 10'h001, 1'b0, 1'b1};
        vecs[10] = '{"up_f1",         10'h201, 10'h001, 1'b1, 10'h200, 1'b1, 1'b0};
        vecs[11] = '{"up_f6_mid",     10'h201, 10'h020, 1'b1, 10'h200, 1'b1, 1'b0};
        vecs[12] = '{"none_pending",  10'h000, 10'h008, 1'b1, 10'h000, 1'b0, 1'b0};

        rst       = 1'b1;
        key_n     = 1'b1;
        floor_sel = 4'd0;
        cur_floor = 10'h000;
        direction = 1'b1;
        serve_ack = 1'b0;
        step(3);
        check_all_zero("reset");
        rst = 1'b0;
        step(2);

        // Invalid floor numbers: one reject pulse each, nothing set.
        rej0 = rej_cnt;
        press(4'd0, 10);
        press(4'd12, 10);
        check("reject_count", 32'(rej_cnt - rej0), 32'd2);
        check("reject_no_set", 32'(floor_reg), 32'h0);

        // Latency: key low after edge P0 -> accept in cycle after P6 -> floor_reg after P7.
        rej0      = rej_cnt;
        floor_sel = 4'd5;
        key_n     = 1'b0;
        step(6);
        check("latency_pre", 32'(floor_reg), 32'h0);
        step(1);
        check("latency_set", 32'(floor_reg), 32'h010);
        step(1);
        check("latency_count", 32'(pend_count), 32'd1);
        check("latency_req_valid", 32'(req_valid), 32'd1);
        step(3);
        key_n = 1'b1;
        step(12);
        check("valid_no_reject", 32'(rej_cnt - rej0), 32'd0);
        model = 10'h010;

        // Bounces of 2 low cycles never reach the debounce count.
        floor_sel = 4'd7;
        for (int g = 0; g < 5; g++) begin
            key_n = 1'b0;
            step(2);
            key_n = 1'b1;
            step(3);
        end
        step(5);
        check("bounce_ignored", 32'(floor_reg), 32'h010);
        rej0 = rej_cnt;
        press(4'd0, 50);
        check("long_hold_one_accept", 32'(rej_cnt - rej0), 32'd1);
        press(4'd7, 50);
        check("long_hold_set", 32'(floor_reg), 32'h050);
        model = 10'h050;

        // SCAN target table.
        foreach (vecs[k]) begin
            load_pending(vecs[k].pending);
            cur_floor = vecs[k].cur;
            direction = vecs[k].dir;
            step(2);
            check({vecs[k].name, "_target"}, 32'(target_floor), 32'(vecs[k].exp_target));
            check({vecs[k].name, "_above"},  32'(target_above), 32'(vecs[k].exp_above));
            check({vecs[k].name, "_below"},  32'(target_below), 32'(vecs[k].exp_below));
            check({vecs[k].name, "_count"},  32'(pend_count), 32'($countones(vecs[k].pending)));
            check({vecs[k].name, "_req_valid"}, 32'(req_valid), 32'(vecs[k].pending != 10'h0));
        end

        // Serve floor 6 while a press for floor 6 is accepted: clear wins.
        load_pending(10'h020);
        cur_floor = 10'h020;
        direction = 1'b1;
        floor_sel = 4'd6;
        key_n     = 1'b0;
        step(6);
        serve_ack = 1'b1;
        step(1);
        serve_ack = 1'b0;
        check("clear_wins", 32'(floor_reg), 32'h0);
        step(1);
        check("clear_wins_req_valid", 32'(req_valid), 32'h0);
        key_n = 1'b1;
        step(12);
        model = 10'h000;

        // Serve floor 6 while floor 3 is accepted: both applied.
        load_pending(10'h020);
        cur_floor = 10'h020;
        floor_sel = 4'd3;
        key_n     = 1'b0;
        step(6);
        serve_ack = 1'b1;
        step(1);
        serve_ack = 1'b0;
        check("set_and_clear", 32'(floor_reg), 32'h004);
        key_n = 1'b1;
        step(12);
        model = 10'h004;

        // Reset mid-debounce with floor 3 pending.
        step(2);
        floor_sel = 4'd8;
        key_n     = 1'b0;
        step(4);
        rst = 1'b1;
        #2;
        check_all_zero("mid_reset");
        key_n = 1'b1;
        step(2);
        rst = 1'b0;
        step(20);
        check("no_accept_after_reset", 32'(floor_reg), 32'h0);
        model = 10'h000;

        // Key held low through reset release is a fresh press.
        key_n = 1'b0;
        rst   = 1'b1;
        step(2);
        rst = 1'b0;
        step(10);
        check("held_through_reset", 32'(floor_reg), 32'h080);
        key_n = 1'b1;
        step(12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
